// File: rtl/fifo_flagged_if.sv
// Handshake/status bundle between a producer/consumer and fifo_flagged.
// The peak port exists only when FIFO_PEAK_EN is defined.
interface fifo_flagged_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                  flush;
   logic                  write_en;
   logic                  read_en;
   logic                  clear_err;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic                  underflow;
`ifdef FIFO_PEAK_EN
   logic [CW-1:0]         peak;

   modport master (
      output flush, write_en, read_en, clear_err, data_in,
      input  data_out, full, empty, almost_full, almost_empty, count,
             overflow, underflow, peak
   );
   modport slave (
      input  flush, write_en, read_en, clear_err, data_in,
      output data_out, full, empty, almost_full, almost_empty, count,
             overflow, underflow, peak
   );
`else
   modport master (
      output flush, write_en, read_en, clear_err, data_in,
      input  data_out, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );
   modport slave (
      input  flush, write_en, read_en, clear_err, data_in,
      output data_out, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );
`endif
endinterface

// File: rtl/fifo_flagged.sv
// Synchronous show-ahead FIFO with level/edge strobes, flush, threshold flags and
// sticky error flags. Define FIFO_PEAK_EN to add the count high-water mark output.
module fifo_flagged #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2,
   parameter bit EDGE_MODE  = 1'b0
) (
   input  logic           clock,
   input  logic           reset,
   fifo_flagged_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;
   logic          wr_hist_q, wr_hist_d;
   logic          rd_hist_q, rd_hist_d;

   logic wr_s, rd_s;
   logic wr_ok, rd_ok;
   logic ovf_set, udf_set;
   logic empty_w, full_w;

   assign empty_w = (count_q == '0);
   assign full_w  = (count_q == DEPTH_C);

   // History resets high so an enable held through reset release is not an edge.
   always_comb begin
      wr_s = bus.write_en;
      rd_s = bus.read_en;
      if (EDGE_MODE) begin
         wr_s = bus.write_en & ~wr_hist_q;
         rd_s = bus.read_en  & ~rd_hist_q;
      end
   end

   always_comb begin
      rd_ok       = rd_s & ~empty_w & ~bus.flush;
      wr_ok       = wr_s & (~full_w | rd_ok) & ~bus.flush;
      ovf_set     = wr_s & ~bus.flush & ~wr_ok;
      udf_set     = rd_s & ~bus.flush & empty_w;

      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      wr_hist_d   = bus.write_en;
      rd_hist_d   = bus.read_en;

      if (bus.flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (wr_ok) wptr_d = wptr_q + AW'(1);
         if (rd_ok) rptr_d = rptr_q + AW'(1);
         case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end

      // A new error in the same cycle takes priority over clear_err.
      overflow_d  = ovf_set | (overflow_q  & ~bus.clear_err);
      underflow_d = udf_set | (underflow_q & ~bus.clear_err);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         wr_hist_q   <= 1'b1;
         rd_hist_q   <= 1'b1;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         wr_hist_q   <= wr_hist_d;
         rd_hist_q   <= rd_hist_d;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_ok) mem_q[wptr_q] <= bus.data_in;
   end

   assign bus.data_out     = mem_q[rptr_q];
   assign bus.count        = count_q;
   assign bus.empty        = empty_w;
   assign bus.full         = full_w;
   assign bus.almost_full  = (count_q >= AF_C);
   assign bus.almost_empty = (count_q <= AE_C);
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

`ifdef FIFO_PEAK_EN
   logic [CW-1:0] peak_q, peak_d;

   always_comb begin
      peak_d = (count_d > peak_q) ? count_d : peak_q;
      if (bus.clear_err) peak_d = '0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) peak_q <= '0;
      else        peak_q <= peak_d;
   end

   assign bus.peak = peak_q;
`endif

   // Pointer distance must always equal occupancy (modulo DEPTH).
   a_count_bound: assert property (@(posedge clock) disable iff (!reset)
      count_q <= DEPTH_C);
   a_ptr_count: assert property (@(posedge clock) disable iff (!reset)
      AW'(wptr_q - rptr_q) == count_q[AW-1:0]);

endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: one level-strobe and one edge-strobe instance share stimulus
// and are checked against a queue-based reference model on every falling edge.
module tb_fifo_flagged;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clock = 1'b0;
   logic rst_n = 1'b0;
   always #5 clock = ~clock;

   logic          t_we = 1'b0, t_re = 1'b0, t_flush = 1'b0, t_clr = 1'b0;
   logic [DW-1:0] t_din = '0;

   fifo_flagged_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) lvl_if ();
   fifo_flagged_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) edg_if ();

   assign lvl_if.write_en  = t_we;
   assign lvl_if.read_en   = t_re;
   assign lvl_if.flush     = t_flush;
   assign lvl_if.clear_err = t_clr;
   assign lvl_if.data_in   = t_din;
   assign edg_if.write_en  = t_we;
   assign edg_if.read_en   = t_re;
   assign edg_if.flush     = t_flush;
   assign edg_if.clear_err = t_clr;
   assign edg_if.data_in   = t_din;

   fifo_flagged #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .EDGE_MODE(1'b0)) u_lvl (
      .clock (clock),
      .reset (rst_n),
      .bus   (lvl_if.slave)
   );
   fifo_flagged #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .EDGE_MODE(1'b1)) u_edg (
      .clock (clock),
      .reset (rst_n),
      .bus   (edg_if.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: index 0 = level strobes, 1 = edge strobes.
   logic [DW-1:0] mq [2][$];
   bit            m_ovf [2];
   bit            m_udf [2];
   bit            m_pwe [2];
   bit            m_prd [2];
   int            m_peak[2];

   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         bit ws, rs, wok, rok, so, su;
         int sz;
         if (!rst_n) begin
            mq[m].delete();
            m_ovf[m] = 0; m_udf[m] = 0;
            m_pwe[m] = 1; m_prd[m] = 1;
            m_peak[m] = 0;
         end else begin
            ws = (m == 1) ? (t_we && !m_pwe[m]) : bit'(t_we);
            rs = (m == 1) ? (t_re && !m_prd[m]) : bit'(t_re);
            m_pwe[m] = t_we;
            m_prd[m] = t_re;
            sz = mq[m].size();
            so = 0; su = 0;
            if (t_flush) begin
               mq[m].delete();
            end else begin
               rok = rs && (sz > 0);
               wok = ws && ((sz < DEPTH) || rok);
               if (rok) void'(mq[m].pop_front());
               if (wok) mq[m].push_back(t_din);
               so = ws && !wok;
               su = rs && (sz == 0);
            end
            m_ovf[m] = so ? 1'b1 : (t_clr ? 1'b0 : m_ovf[m]);
            m_udf[m] = su ? 1'b1 : (t_clr ? 1'b0 : m_udf[m]);
            if (t_clr)                           m_peak[m] = 0;
            else if (mq[m].size() > m_peak[m])   m_peak[m] = mq[m].size();
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clock or negedge rst_n);
         model_step();
      end
   end

   task automatic check_dut(input int m, input string tag, input logic [DW-1:0] dout,
                            input logic [CW-1:0] cnt, input logic fl, input logic em,
                            input logic af, input logic ae, input logic ov,
                            input logic un, input logic [CW-1:0] pk);
      int sz;
      sz = mq[m].size();
      chk({tag, ".count"}, 32'(cnt), 32'(sz));
      chk({tag, ".empty"}, 32'(em), 32'(sz == 0));
      chk({tag, ".full"}, 32'(fl), 32'(sz == DEPTH));
      chk({tag, ".almost_full"}, 32'(af), 32'(sz >= DEPTH - 2));
      chk({tag, ".almost_empty"}, 32'(ae), 32'(sz <= 2));
      chk({tag, ".overflow"}, 32'(ov), 32'(m_ovf[m]));
      chk({tag, ".underflow"}, 32'(un), 32'(m_udf[m]));
      if (sz > 0) chk({tag, ".data_out"}, 32'(dout), 32'(mq[m][0]));
`ifdef FIFO_PEAK_EN
      chk({tag, ".peak"}, 32'(pk), 32'(m_peak[m]));
`else
      if (pk !== '0) chk({tag, ".peak_tieoff"}, 32'(pk), 32'd0);
`endif
   endtask

   // Scoreboard monitor, away from the active edge.
   initial begin
      logic [CW-1:0] pk0, pk1;
      forever begin
         @(negedge clock);
`ifdef FIFO_PEAK_EN
         pk0 = lvl_if.peak; pk1 = edg_if.peak;
`else
         pk0 = '0; pk1 = '0;
`endif
         check_dut(0, "lvl", lvl_if.data_out, lvl_if.count, lvl_if.full, lvl_if.empty,
                   lvl_if.almost_full, lvl_if.almost_empty, lvl_if.overflow,
                   lvl_if.underflow, pk0);
         check_dut(1, "edg", edg_if.data_out, edg_if.count, edg_if.full, edg_if.empty,
                   edg_if.almost_full, edg_if.almost_empty, edg_if.overflow,
                   edg_if.underflow, pk1);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
      $fatal(1, "timeout");
   end

   initial begin
      int wp, rp;
      repeat (3) step();
      chk("rst.empty", 32'(lvl_if.empty), 32'd1);
      chk("rst.almost_empty", 32'(lvl_if.almost_empty), 32'd1);
      chk("rst.full", 32'(lvl_if.full), 32'd0);
      rst_n = 1'b1;
      step();

      // 16 back-to-back level writes.
      for (int i = 1; i <= DEPTH; i++) begin
         t_we = 1'b1; t_din = DW'(i);
         step();
         chk("tp1.count", 32'(lvl_if.count), 32'(i));
         chk("tp1.almost_full", 32'(lvl_if.almost_full), 32'(i >= 14));
         chk("tp1.full", 32'(lvl_if.full), 32'(i == DEPTH));
         chk("tp1.data_out", 32'(lvl_if.data_out), 32'h01);
      end
      t_we = 1'b0; step();

      // Simultaneous read/write while full.
      t_we = 1'b1; t_re = 1'b1; t_din = 8'hAA; step();
      t_we = 1'b0; t_re = 1'b0;
      chk("tp2.count", 32'(lvl_if.count), 32'd16);
      chk("tp2.data_out", 32'(lvl_if.data_out), 32'h02);
      chk("tp2.overflow", 32'(lvl_if.overflow), 32'd0);
      step();

      // Refused write while full, then clear.
      t_we = 1'b1; t_din = 8'h55; step();
      t_we = 1'b0;
      chk("tp3.overflow", 32'(lvl_if.overflow), 32'd1);
      chk("tp3.count", 32'(lvl_if.count), 32'd16);
      t_clr = 1'b1; step();
      t_clr = 1'b0;
      chk("tp3.overflow_clr", 32'(lvl_if.overflow), 32'd0);

      t_re = 1'b1;
      for (int i = 1; i <= DEPTH; i++) begin
         step();
         if (i == DEPTH - 1) chk("tp2.last_word", 32'(lvl_if.data_out), 32'hAA);
      end
      t_re = 1'b0;
      chk("drain.empty", 32'(lvl_if.empty), 32'd1);
      step();

      // Read on empty with a same-cycle write: no bypass.
      t_re = 1'b1; t_we = 1'b1; t_din = 8'h33; step();
      t_re = 1'b0; t_we = 1'b0;
      chk("tp4.underflow", 32'(lvl_if.underflow), 32'd1);
      chk("tp4.count", 32'(lvl_if.count), 32'd1);
      chk("tp4.data_out", 32'(lvl_if.data_out), 32'h33);
      t_clr = 1'b1; step(); t_clr = 1'b0;

      // Edge mode: held enable writes once; enable held across reset release is ignored.
      t_flush = 1'b1; step(); t_flush = 1'b0;
      t_we = 1'b1; t_din = 8'h77;
      repeat (5) step();
      chk("tp5.edg_count", 32'(edg_if.count), 32'd1);
      t_we = 1'b0; step();
      t_we = 1'b1; rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      repeat (2) step();
      chk("tp5.edg_rst_count", 32'(edg_if.count), 32'd0);
      chk("tp5.edg_rst_empty", 32'(edg_if.empty), 32'd1);
      t_we = 1'b0; step();

      // Flush with a concurrent write after loading 9 words.
      t_flush = 1'b1; step(); t_flush = 1'b0;
      t_re = 1'b1; step(); t_re = 1'b0;
      for (int i = 0; i < 9; i++) begin
         t_we = 1'b1; t_din = DW'(8'h90 + i); step();
         t_we = 1'b0; step();
      end
      chk("tp6.count9", 32'(edg_if.count), 32'd9);
      t_flush = 1'b1; t_we = 1'b1; step();
      t_flush = 1'b0; t_we = 1'b0;
      chk("tp6.lvl_count", 32'(lvl_if.count), 32'd0);
      chk("tp6.edg_empty", 32'(edg_if.empty), 32'd1);
      chk("tp6.lvl_underflow", 32'(lvl_if.underflow), 32'd1);
      chk("tp6.edg_overflow", 32'(edg_if.overflow), 32'd0);
`ifdef FIFO_PEAK_EN
      chk("tp6.lvl_peak", 32'(lvl_if.peak), 32'd9);
      chk("tp6.edg_peak", 32'(edg_if.peak), 32'd9);
`endif
      step();

      // Randomised phases with varying write/read pressure.
      for (int p = 0; p < 40; p++) begin
         wp = $urandom_range(10, 90);
         rp = $urandom_range(10, 90);
         for (int c = 0; c < 100; c++) begin
            t_we    = ($urandom_range(0, 99) < wp);
            t_re    = ($urandom_range(0, 99) < rp);
            t_din   = DW'($urandom);
            t_flush = ($urandom_range(0, 63) == 0);
            t_clr   = !t_flush && ($urandom_range(0, 47) == 0);
            rst_n   = ($urandom_range(0, 999) != 0);
            step();
         end
      end
      rst_n = 1'b1;
      t_we = 1'b0; t_re = 1'b0; t_flush = 1'b0; t_clr = 1'b0;
      repeat (2) step();
      @(negedge clock);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_flagged.md
Name: fifo_flagged

Overview:
- Parametrised synchronous FIFO. Successor to the team's basic strobe FIFO.
- Adds level or edge strobe mode, simultaneous read/write when full, flush, almost-full/almost-empty thresholds, occupancy count output, and sticky overflow/underflow error flags.
- Sits between host-side command/byte producers (UART/SPI receive paths) and consumers in the TangNano20K designs. One clock domain.

Parameters:
- DATA_WIDTH, 8, data word width in bits (≥1).
- DEPTH, 16, number of entries; power of two, ≥2.
- AF_LEVEL, DEPTH-2, almost_full asserted when count ≥ AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserted when count ≤ AE_LEVEL (0..DEPTH-1).
- EDGE_MODE, 0, selects the strobe mode. 0 = write_en/read_en are level strobes, one access per high cycle. 1 = only the rising edge of each enable counts as a strobe.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; deassertion is synchronous to clock.
- flush  in  1  synchronous clear of FIFO contents.
- write_en  in  1  write request.
- read_en  in  1  read request.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  head-of-FIFO word (show-ahead).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: write strobe refused.
- underflow  out  1  sticky: read strobe refused.
- clear_err  in  1  synchronous clear of overflow/underflow (and peak).

Behaviour:
- Reset (reset low): write pointer, read pointer and count = 0; overflow = underflow = 0; empty = 1, full = 0, almost_empty = 1, almost_full = 0. Edge-detect history registers = 1, so an enable held high through reset release is not a strobe.
- Storage array is not reset. data_out is undefined while empty.
- Strobes:
  - EDGE_MODE = 0: wr_s = write_en, rd_s = read_en.
  - EDGE_MODE = 1: wr_s = write_en & ~write_en_d, rd_s = read_en & ~read_en_d, where the _d registers update every cycle.
- Read accept: rd_ok = rd_s & ~empty. No bypass: a read on an empty FIFO is refused even if a write occurs in the same cycle.
- Write accept: wr_ok = wr_s & (~full | rd_ok). When full, a simultaneous read and write both succeed and count stays at DEPTH.
- Writes: on wr_ok, mem[wptr] <= data_in and wptr increments.
- Reads: on rd_ok, rptr increments.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged for both or neither. Never exceeds DEPTH and never goes below 0.
- data_out = mem[rptr], combinational (show-ahead). A written word is visible on data_out the cycle after its write when the FIFO was empty (latency 1).
- Flags full, empty, almost_full and almost_empty are combinational decodes of the registered count, so they update 1 cycle after the accepting edge.
- Error flags:
  - overflow sets on wr_s & ~wr_ok.
  - underflow sets on rd_s & empty.
  - clear_err clears both. A set in the same cycle wins over clear_err.
- Flush:
  - Next edge: wptr = rptr = count = 0.
  - Any write or read in the same cycle is ignored and raises no error.
  - Error flags are held. Edge history still updates.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), regardless of strobes.

Optional Feature:
- Macro: FIFO_PEAK_EN.
- With the macro defined:
  - Adds output port peak [$clog2(DEPTH):0], the high-water mark of count.
  - peak <= max(peak, next count) every cycle.
  - Reset and clear_err both set peak to 0; flush does not.
- Without the macro: no peak port and no associated logic.

Test Plan:
- Reset, then EDGE_MODE=0, DEPTH=16: write 0x01..0x10 on 16 consecutive cycles -> full=1 and count=16 after the last edge; almost_full rises when count reaches 14; data_out=0x01 throughout.
- Full FIFO, assert write_en and read_en together for 1 cycle with data_in=0xAA -> count stays 16; data_out becomes 0x02; overflow stays 0; 0xAA is read out last.
- Full FIFO, write_en alone with 0x55 -> overflow=1 next cycle, count=16. Then pulse clear_err -> overflow=0.
- Empty FIFO, read_en and write_en(0x33) in the same cycle -> underflow=1, count=1, data_out=0x33 on the next cycle.
- EDGE_MODE=1: hold write_en high for 5 cycles with data_in=0x77 -> exactly one entry written, count=1. Hold write_en high across reset release -> no write.
- Load 9 words, assert flush together with write_en -> count=0 and empty=1 next cycle, error flags unchanged. With FIFO_PEAK_EN defined, peak=9.
